// File: rtl/pq_accel_seq_id.sv
// PQ accelerator sequencer: parameter-set table, NTT mode flags and the
// Keccak round sequencer that steals the PQ/GP register write ports from
// the NTT datapath while a permutation is running.
//
// Keccak FSM states:
//   state    | meaning
//   ST_IDLE  | core held in reset, NTT owns the register write ports
//   ST_ROUND | one permutation round per cycle, core output written back
//   ST_DONE  | single-cycle completion pulse, no writes
module pq_accel_seq_id #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int NUM_GP_REGS    = 18,
    parameter int KECCAK_ROUNDS  = 24,
    parameter int NUM_PARAM_SETS = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           cfg_set,
    input  logic [1:0]                                     cfg_sel,
    input  logic                                           set_fwd_ntt,
    input  logic                                           set_inv_ntt,
    input  logic                                           set_first_rounds,
    input  logic                                           set_last_round,
    input  logic                                           ntt_busy_i,
    output logic [10:0]                                    param_n_o,
    output logic [15:0]                                    modulus_o,
    output logic [17:0]                                    minqinv_o,
    output logic                                           fwd_ntt_o,
    output logic                                           first_rounds_o,
    output logic                                           cfg_pending_o,
    input  logic                                           keccak_start,
    input  logic                                           keccak_abort,
    output logic                                           keccak_busy_o,
    output logic                                           keccak_done_o,
    output logic [4:0]                                     keccak_round_o,
    output logic                                           keccak_core_rst_o,
    input  logic [NUM_REGS+NUM_GP_REGS-1:0][DATA_WIDTH-1:0] keccak_wdata_i,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]            ntt_wdata_i,
    input  logic [NUM_REGS-1:0]                            ntt_we_i,
    output logic                                           ntt_stall_o,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]            wdata_pq_o,
    output logic [NUM_REGS-1:0]                            we_pq_o,
    output logic [NUM_GP_REGS-1:0][DATA_WIDTH-1:0]         wdata_pq_gp_o,
    output logic [NUM_GP_REGS-1:0]                         we_pq_gp_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(KECCAK_ROUNDS - 1);
    localparam logic [2:0] NUM_SETS   = 3'(NUM_PARAM_SETS);

    state_t     state;
    logic [4:0] round_cnt;
    logic       busy_q;
    logic       done_q;
    logic       core_rst_q;

    logic [1:0] pend_sel;
    logic       cfg_valid;
    logic       apply_en;
    logic [1:0] apply_sel;
    logic       keccak_wr;

    // (param_n, modulus, minqinv) packed as 11+16+18 bits
    function automatic logic [44:0] param_entry(input logic [1:0] sel);
        case (sel)
            2'd0:    return {11'h100, 16'h0D01, 18'h30CFF};
            2'd1:    return {11'h200, 16'h3001, 18'h02FFF};
            2'd2:    return {11'h400, 16'h3001, 18'h02FFF};
            default: return {11'h100, 16'h1E01, 18'h01DFF};
        endcase
    endfunction

    assign cfg_valid = cfg_set && ({1'b0, cfg_sel} < NUM_SETS);

    // A fresh valid request beats a stale pending index when the NTT is free
    always_comb begin
        apply_en  = 1'b0;
        apply_sel = cfg_sel;
        if (!ntt_busy_i) begin
            if (cfg_valid) begin
                apply_en = 1'b1;
            end else if (cfg_pending_o) begin
                apply_en  = 1'b1;
                apply_sel = pend_sel;
            end
        end
    end

    // Parameter registers and the deferred-load holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            {param_n_o, modulus_o, minqinv_o} <= param_entry(2'd3);
            cfg_pending_o <= 1'b0;
            pend_sel      <= 2'd0;
        end else begin
            if (apply_en) begin
                {param_n_o, modulus_o, minqinv_o} <= param_entry(apply_sel);
            end
            if (ntt_busy_i) begin
                if (cfg_valid) begin
                    cfg_pending_o <= 1'b1;
                    pend_sel      <= cfg_sel;
                end
            end else begin
                cfg_pending_o <= 1'b0;
            end
        end
    end

    // Mode flags: the set request wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_ntt_o      <= 1'b1;
            first_rounds_o <= 1'b1;
        end else begin
            if (set_fwd_ntt) begin
                fwd_ntt_o <= 1'b1;
            end else if (set_inv_ntt) begin
                fwd_ntt_o <= 1'b0;
            end
            if (set_first_rounds) begin
                first_rounds_o <= 1'b1;
            end else if (set_last_round) begin
                first_rounds_o <= 1'b0;
            end
        end
    end

    // Keccak sequencer; status outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            round_cnt  <= 5'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (keccak_start) begin
                        state      <= ST_ROUND;
                        round_cnt  <= 5'd0;
                        busy_q     <= 1'b1;
                        core_rst_q <= 1'b0;
                    end
                end
                ST_ROUND: begin
                    if (keccak_abort) begin
                        state      <= ST_IDLE;
                        round_cnt  <= 5'd0;
                        busy_q     <= 1'b0;
                        core_rst_q <= 1'b1;
                    end else if (round_cnt == LAST_ROUND) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        round_cnt <= round_cnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    round_cnt  <= 5'd0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    core_rst_q <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    round_cnt  <= 5'd0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    core_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign keccak_busy_o     = busy_q;
    assign keccak_done_o     = done_q;
    assign keccak_core_rst_o = core_rst_q;
    assign keccak_round_o    = round_cnt;
    assign ntt_stall_o       = busy_q;

    // Abort or reset during a round kills that round's write-back at once
    assign keccak_wr = (state == ST_ROUND) && !keccak_abort && !rst;

    // Write-port arbitration between the Keccak core and the NTT datapath
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wdata_pq_o[i] = (state == ST_ROUND) ? keccak_wdata_i[i] : ntt_wdata_i[i];
        end
        for (int g = 0; g < NUM_GP_REGS; g++) begin
            wdata_pq_gp_o[g] = keccak_wdata_i[NUM_REGS+g];
        end
        we_pq_o    = '0;
        we_pq_gp_o = '0;
        if (keccak_wr) begin
            we_pq_o    = '1;
            we_pq_gp_o = '1;
        end else if (!busy_q) begin
            we_pq_o = ntt_we_i;
        end
    end

endmodule

// File: tb/tb_pq_accel_seq_id.sv
// Scoreboard bench for pq_accel_seq_id: stimulus pushes cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_pq_accel_seq_id;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NG  = 18;
    localparam int KR  = 24;
    localparam int NPS = 3;

    localparam int K_IDLE  = 0;
    localparam int K_WRITE = 1;
    localparam int K_DONE  = 2;
    localparam int K_ABORT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    cfg_set;
    logic [1:0]              cfg_sel;
    logic                    set_fwd_ntt, set_inv_ntt, set_first_rounds, set_last_round;
    logic                    ntt_busy_i;
    logic [10:0]             param_n_o;
    logic [15:0]             modulus_o;
    logic [17:0]             minqinv_o;
    logic                    fwd_ntt_o, first_rounds_o, cfg_pending_o;
    logic                    keccak_start, keccak_abort;
    logic                    keccak_busy_o, keccak_done_o, keccak_core_rst_o;
    logic [4:0]              keccak_round_o;
    logic [NR+NG-1:0][DW-1:0] keccak_wdata_i;
    logic [NR-1:0][DW-1:0]   ntt_wdata_i;
    logic [NR-1:0]           ntt_we_i;
    logic                    ntt_stall_o;
    logic [NR-1:0][DW-1:0]   wdata_pq_o;
    logic [NR-1:0]           we_pq_o;
    logic [NG-1:0][DW-1:0]   wdata_pq_gp_o;
    logic [NG-1:0]           we_pq_gp_o;

    pq_accel_seq_id #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_GP_REGS(NG),
        .KECCAK_ROUNDS(KR), .NUM_PARAM_SETS(NPS)
    ) dut (
        .clk(clk), .rst(rst), .cfg_set(cfg_set), .cfg_sel(cfg_sel),
        .set_fwd_ntt(set_fwd_ntt), .set_inv_ntt(set_inv_ntt),
        .set_first_rounds(set_first_rounds), .set_last_round(set_last_round),
        .ntt_busy_i(ntt_busy_i), .param_n_o(param_n_o), .modulus_o(modulus_o),
        .minqinv_o(minqinv_o), .fwd_ntt_o(fwd_ntt_o), .first_rounds_o(first_rounds_o),
        .cfg_pending_o(cfg_pending_o), .keccak_start(keccak_start),
        .keccak_abort(keccak_abort), .keccak_busy_o(keccak_busy_o),
        .keccak_done_o(keccak_done_o), .keccak_round_o(keccak_round_o),
        .keccak_core_rst_o(keccak_core_rst_o), .keccak_wdata_i(keccak_wdata_i),
        .ntt_wdata_i(ntt_wdata_i), .ntt_we_i(ntt_we_i), .ntt_stall_o(ntt_stall_o),
        .wdata_pq_o(wdata_pq_o), .we_pq_o(we_pq_o), .wdata_pq_gp_o(wdata_pq_gp_o),
        .we_pq_gp_o(we_pq_gp_o)
    );

    int n_tab[4] = '{'h100, 'h200, 'h400, 'h100};
    int m_tab[4] = '{'h0D01, 'h3001, 'h3001, 'h1E01};
    int q_tab[4] = '{'h30CFF, 'h02FFF, 'h02FFF, 'h01DFF};

    typedef struct { int cyc; int kind; int rnd; logic [NR-1:0] nwe; } kexp_t;
    typedef struct { int cyc; int set; bit fwd; bit first; bit pend; } cexp_t;

    kexp_t kq[$];
    cexp_t cq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    // reference model state
    int m_cur, m_psel;
    bit m_pend, m_fwd, m_first;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    kexp_t me;
    cexp_t mc;
    int    mj, mg;

    always @(negedge clk) begin
        if (mon_on) begin
            if (cq.size() > 0 && cq[0].cyc == cyc) begin
                mc = cq.pop_front();
                chk("param_n", 64'(param_n_o), 64'(n_tab[mc.set]));
                chk("modulus", 64'(modulus_o), 64'(m_tab[mc.set]));
                chk("minqinv", 64'(minqinv_o), 64'(q_tab[mc.set]));
                chk("flags_fwd_first_pend", {61'd0, fwd_ntt_o, first_rounds_o, cfg_pending_o},
                    {61'd0, mc.fwd, mc.first, mc.pend});
            end
            mj = $urandom_range(0, NR - 1);
            mg = $urandom_range(0, NG - 1);
            if (kq.size() > 0 && kq[0].cyc == cyc) begin
                me = kq.pop_front();
                case (me.kind)
                    K_IDLE: begin
                        chk("idle_we_pass", 64'(we_pq_o), 64'(me.nwe));
                        chk("idle_wdata_pass", 64'(wdata_pq_o[mj]), 64'(ntt_wdata_i[mj]));
                        chk("idle_status_gp_stall_busy_done_crst",
                            {59'd0, |we_pq_gp_o, ntt_stall_o, keccak_busy_o, keccak_done_o, keccak_core_rst_o},
                            {59'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
                    end
                    K_WRITE: begin
                        chk("round_idx", 64'(keccak_round_o), 64'(me.rnd));
                        chk("round_we_pq", 64'(we_pq_o), {32'd0, {NR{1'b1}}});
                        chk("round_we_gp", 64'(we_pq_gp_o), 64'(18'h3FFFF));
                        chk("round_wdata_pq", 64'(wdata_pq_o[mj]), 64'(keccak_wdata_i[mj]));
                        chk("round_wdata_gp", 64'(wdata_pq_gp_o[mg]), 64'(keccak_wdata_i[NR+mg]));
                        chk("round_status_stall_busy_done_crst",
                            {60'd0, ntt_stall_o, keccak_busy_o, keccak_done_o, keccak_core_rst_o},
                            {60'd0, 1'b1, 1'b1, 1'b0, 1'b0});
                    end
                    K_DONE: begin
                        chk("done_pulse", 64'(keccak_done_o), 64'd1);
                        chk("done_no_writes", {31'd0, we_pq_o, 14'd0, we_pq_gp_o}, 64'd0);
                        chk("done_busy_stall", {62'd0, keccak_busy_o, ntt_stall_o}, 64'd3);
                    end
                    default: begin
                        chk("abort_no_writes", {31'd0, we_pq_o, 14'd0, we_pq_gp_o}, 64'd0);
                        chk("abort_no_done", 64'(keccak_done_o), 64'd0);
                    end
                endcase
            end else begin
                chk("spurious_keccak", {62'd0, keccak_done_o, |we_pq_gp_o}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR + NG; i++) keccak_wdata_i[i] = $urandom;
        for (int i = 0; i < NR; i++) ntt_wdata_i[i] = $urandom;
    endtask

    task automatic model_reset();
        m_cur = 3; m_psel = 0; m_pend = 1'b0; m_fwd = 1'b1; m_first = 1'b1;
    endtask

    task automatic cfg_cycle(input bit s, input logic [1:0] sel, input bit busy,
                             input bit sf, input bit si, input bit sfr, input bit slr);
        bit valid;
        cfg_set = s; cfg_sel = sel; ntt_busy_i = busy;
        set_fwd_ntt = sf; set_inv_ntt = si; set_first_rounds = sfr; set_last_round = slr;
        ntt_we_i = $urandom;
        rand_data();
        kq.push_back('{cyc, K_IDLE, 0, ntt_we_i});
        valid = s && (int'(sel) < NPS);
        if (busy) begin
            if (valid) begin m_pend = 1'b1; m_psel = int'(sel); end
        end else if (valid) begin
            m_cur = int'(sel); m_pend = 1'b0;
        end else if (m_pend) begin
            m_cur = m_psel; m_pend = 1'b0;
        end
        if (sf) m_fwd = 1'b1; else if (si) m_fwd = 1'b0;
        if (sfr) m_first = 1'b1; else if (slr) m_first = 1'b0;
        cq.push_back('{cyc + 1, m_cur, m_fwd, m_first, m_pend});
        tick();
    endtask

    // abort_r / rst_r: round at which to abort or reset (-1 = never)
    task automatic run_keccak(input int abort_r, input int rst_r, input bit fixed_we);
        bit stopped = 1'b0;
        cfg_set = 0; ntt_busy_i = 0; set_fwd_ntt = 0; set_inv_ntt = 0;
        set_first_rounds = 0; set_last_round = 0;
        ntt_we_i = fixed_we ? NR'(32'hF) : NR'($urandom);
        rand_data();
        keccak_start = 1'b1;
        kq.push_back('{cyc, K_IDLE, 0, ntt_we_i});
        tick();
        for (int r = 0; r < KR && !stopped; r++) begin
            rand_data();
            if (!fixed_we) ntt_we_i = $urandom;
            keccak_start = 1'($urandom_range(0, 1));
            if (r == abort_r) begin
                keccak_abort = 1'b1; keccak_start = 1'b1;
                kq.push_back('{cyc, K_ABORT, r, '0});
                stopped = 1'b1;
            end else if (r == rst_r) begin
                rst = 1'b1;
                kq.push_back('{cyc, K_ABORT, r, '0});
                stopped = 1'b1;
            end else begin
                kq.push_back('{cyc, K_WRITE, r, '0});
            end
            tick();
        end
        keccak_abort = 1'b0;
        if (rst) begin
            rst = 1'b0;
            model_reset();
            cq.push_back('{cyc, m_cur, m_fwd, m_first, m_pend});
        end
        if (!stopped) begin
            keccak_start = 1'b1;
            rand_data();
            kq.push_back('{cyc, K_DONE, 0, '0});
            tick();
        end
        keccak_start = 1'b0;
        rand_data();
        kq.push_back('{cyc, K_IDLE, 0, ntt_we_i});
        tick();
    endtask

    initial begin
        rst = 1'b1; cfg_set = 0; cfg_sel = 0; ntt_busy_i = 0;
        set_fwd_ntt = 0; set_inv_ntt = 0; set_first_rounds = 0; set_last_round = 0;
        keccak_start = 0; keccak_abort = 0; ntt_we_i = '0;
        rand_data();
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        mon_on = 1'b1;
        cq.push_back('{cyc, m_cur, m_fwd, m_first, m_pend});
        kq.push_back('{cyc, K_IDLE, 0, ntt_we_i});
        tick();

        // immediate load of set 1
        cfg_cycle(1, 2'd1, 0, 0, 0, 0, 0);
        cfg_cycle(0, 2'd0, 0, 0, 0, 0, 0);
        // deferred load, last writer wins
        cfg_cycle(1, 2'd0, 1, 0, 0, 0, 0);
        cfg_cycle(1, 2'd2, 1, 0, 0, 0, 0);
        cfg_cycle(0, 2'd0, 1, 0, 0, 0, 0);
        cfg_cycle(0, 2'd0, 0, 0, 0, 0, 0);
        cfg_cycle(0, 2'd0, 0, 0, 0, 0, 0);
        // flag priority
        cfg_cycle(0, 2'd0, 0, 1, 1, 0, 0);
        cfg_cycle(0, 2'd0, 0, 0, 1, 0, 0);
        cfg_cycle(0, 2'd0, 0, 0, 0, 1, 1);
        cfg_cycle(0, 2'd0, 0, 0, 0, 0, 1);
        // out-of-range index ignored, both direct and deferred
        cfg_cycle(1, 2'd3, 0, 0, 0, 0, 0);
        cfg_cycle(1, 2'd3, 1, 0, 0, 0, 0);
        cfg_cycle(0, 2'd0, 0, 0, 0, 0, 0);

        repeat (300) begin
            cfg_cycle(1'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        cfg_cycle(0, 2'd0, 0, 0, 0, 0, 0);

        run_keccak(-1, -1, 1'b1);
        cfg_cycle(0, 2'd0, 0, 0, 0, 0, 0);
        run_keccak(5, -1, 1'b0);
        cfg_cycle(0, 2'd0, 0, 0, 0, 0, 0);
        run_keccak(-1, 10, 1'b0);
        cfg_cycle(1, 2'd2, 0, 0, 1, 0, 1);
        run_keccak(-1, -1, 1'b0);
        cfg_cycle(0, 2'd0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("scoreboard_drained", 64'(kq.size() + cq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
